// File: rtl/dds_sweep.sv
// Direct digital synthesiser: phase accumulator, external table lookup, shape/scale stages and a linear sweep engine.
// Samples are offset binary; q follows tbl_addr by two cycles, and register writes take effect on the next cycle.
module dds_sweep #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int PW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [31:0]   cfg_wdata,
  input  logic          sync,
  input  logic [DW-1:0] tbl_data,
  output logic [AW-1:0] tbl_addr,
  output logic [DW-1:0] q,
  output logic          wrap,
  output logic          sweep_busy,
  output logic [PW-1:0] cur_inc
);

  localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};
  localparam int PRW = 2*DW + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  logic [5:0]    r_ctrl;
  logic [PW-1:0] r_freq;
  logic [PW-1:0] r_ofs;
  logic [DW:0]   r_amp;
  logic [PW-1:0] r_step;
  logic [PW-1:0] r_end;
  logic [15:0]   r_div;

  logic [PW-1:0] r_phase;
  logic [PW-1:0] r_inc;
  logic [15:0]   r_presc;
  logic          r_reload;
  state_t        r_state;
  logic [DW-1:0] r_slice;
  logic [DW-1:0] r_slice_d;

  logic          w_wr_ctrl;
  logic          w_wr_freq;
  logic          w_wr_end;
  logic [PW-1:0] w_freq_nxt;
  logic [PW-1:0] w_end_nxt;
  logic [PW-1:0] w_sum;
  logic [DW-1:0] w_tri;
  logic [DW-1:0] w_shape;
  logic [DW-1:0] w_s;
  logic signed [DW-1:0]  w_x;
  logic signed [PRW-1:0] w_prod;
  logic signed [PRW-1:0] w_shift;
  logic [PRW-DW:0]       w_hi;
  logic [DW-1:0]         w_y;
  logic signed [PW+1:0]  w_n;
  logic signed [PW+1:0]  w_end_ext;
  logic                  w_hit;
  state_t        w_state_nxt;
  logic [PW-1:0] w_inc_nxt;
  logic [15:0]   w_presc_nxt;
  logic          w_reload_nxt;
  logic          w_unused;

  assign w_wr_ctrl  = cfg_we && (cfg_addr == 3'd0);
  assign w_wr_freq  = cfg_we && (cfg_addr == 3'd1);
  assign w_wr_end   = cfg_we && (cfg_addr == 3'd5);
  assign w_freq_nxt = w_wr_freq ? cfg_wdata[PW-1:0] : r_freq;
  assign w_end_nxt  = w_wr_end ? cfg_wdata[PW-1:0] : r_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl <= '0;
      r_freq <= '0;
      r_ofs  <= '0;
      r_amp  <= {1'b1, {DW{1'b0}}};
      r_step <= '0;
      r_end  <= '0;
      r_div  <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        3'd0:    r_ctrl <= cfg_wdata[5:0];
        3'd1:    r_freq <= cfg_wdata[PW-1:0];
        3'd2:    r_ofs  <= cfg_wdata[PW-1:0];
        3'd3:    r_amp  <= cfg_wdata[DW:0];
        3'd4:    r_step <= cfg_wdata[PW-1:0];
        3'd5:    r_end  <= cfg_wdata[PW-1:0];
        3'd6:    r_div  <= cfg_wdata[15:0];
        default: ;
      endcase
    end
  end

  assign w_sum = r_phase + r_ofs;

  always_comb begin
    w_tri = {r_slice_d[DW-2:0], 1'b0};
    case (r_ctrl[3:2])
      2'd0:    w_shape = tbl_data;
      2'd1:    w_shape = {DW{~r_slice_d[DW-1]}};
      2'd2:    w_shape = r_slice_d;
      default: w_shape = r_slice_d[DW-1] ? ~w_tri : w_tri;
    endcase
    w_s = r_ctrl[1] ? ~w_shape : w_shape;
  end

  // Signed scale; anything outside the DW-bit signed range saturates.
  assign w_x     = $signed(w_s ^ MID);
  assign w_prod  = w_x * $signed({1'b0, r_amp});
  assign w_shift = w_prod >>> DW;
  assign w_hi    = w_shift[PRW-1:DW-1];
  always_comb begin
    if ((&w_hi) || !(|w_hi)) begin
      w_y = w_shift[DW-1:0];
    end else if (w_shift[PRW-1]) begin
      w_y = {1'b1, {(DW-1){1'b0}}};
    end else begin
      w_y = {1'b0, {(DW-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase   <= '0;
      wrap      <= 1'b0;
      tbl_addr  <= '0;
      r_slice   <= '0;
      r_slice_d <= '0;
      q         <= MID;
    end else begin
      if (sync) begin
        r_phase <= '0;
        wrap    <= 1'b0;
      end else begin
        {wrap, r_phase} <= {1'b0, r_phase} + {1'b0, r_inc};
      end
      tbl_addr  <= w_sum[PW-1 -: AW];
      r_slice   <= w_sum[PW-1 -: DW];
      r_slice_d <= r_slice;
      q         <= r_ctrl[0] ? (w_y ^ MID) : MID;
    end
  end

  // Sweep step computed two bits wider so the end comparison cannot wrap.
  assign w_n       = $signed({2'b00, r_inc}) + $signed({{2{r_step[PW-1]}}, r_step});
  assign w_end_ext = $signed({2'b00, r_end});
  assign w_hit     = r_step[PW-1] ? (w_n <= w_end_ext) : (w_n >= w_end_ext);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_inc    <= '0;
      r_presc  <= '0;
      r_reload <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_inc    <= w_inc_nxt;
      r_presc  <= w_presc_nxt;
      r_reload <= w_reload_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_inc_nxt    = r_inc;
    w_presc_nxt  = r_presc;
    w_reload_nxt = r_reload;
    case (r_state)
      S_IDLE: begin
        w_inc_nxt = w_freq_nxt;
        if (w_wr_ctrl && cfg_wdata[4]) begin
          w_state_nxt  = S_RUN;
          w_inc_nxt    = r_freq;
          w_presc_nxt  = '0;
          w_reload_nxt = 1'b0;
        end
      end
      S_RUN: begin
        if (w_wr_ctrl && !cfg_wdata[4]) begin
          w_state_nxt = S_IDLE;
          w_inc_nxt   = r_freq;
        end else if (w_wr_ctrl || w_wr_freq) begin
          w_inc_nxt    = w_freq_nxt;
          w_presc_nxt  = '0;
          w_reload_nxt = 1'b0;
        end else if (r_presc == r_div) begin
          w_presc_nxt = '0;
          if (r_reload) begin
            w_inc_nxt    = r_freq;
            w_reload_nxt = 1'b0;
          end else if (w_hit) begin
            w_inc_nxt = r_end;
            if (r_ctrl[5]) begin
              w_reload_nxt = 1'b1;
            end else begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_inc_nxt = w_n[PW-1:0];
          end
        end else begin
          w_presc_nxt = r_presc + 16'd1;
        end
      end
      S_DONE: begin
        w_inc_nxt = w_end_nxt;
        if (w_wr_ctrl) begin
          w_state_nxt  = cfg_wdata[4] ? S_RUN : S_IDLE;
          w_inc_nxt    = r_freq;
          w_presc_nxt  = '0;
          w_reload_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign cur_inc    = r_inc;
  assign sweep_busy = (r_state == S_RUN);
  assign w_unused   = ^{w_sum, r_ctrl[4]};

endmodule

// File: tb/tb_dds_sweep.sv
// Directed bench for dds_sweep with a synchronous identity/constant waveform table model.
module tb_dds_sweep;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        sync;
  logic [7:0]  tbl_data;
  logic [7:0]  tbl_addr;
  logic [7:0]  q;
  logic        wrap;
  logic        sweep_busy;
  logic [31:0] cur_inc;
  logic        tbl_const;

  int n_pass;
  int n_chk;
  int k;

  dds_sweep #(.AW(8), .DW(8), .PW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .sync       (sync),
    .tbl_data   (tbl_data),
    .tbl_addr   (tbl_addr),
    .q          (q),
    .wrap       (wrap),
    .sweep_busy (sweep_busy),
    .cur_inc    (cur_inc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) tbl_data <= 8'h00;
    else     tbl_data <= tbl_const ? 8'hFF : tbl_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_sync();
    @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    k = 0;
  endtask

  task automatic step_to(input int t);
    while (k < t) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    n_pass = 0; n_chk = 0; k = 0;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 32'd0;
    sync = 1'b0; tbl_const = 1'b0;

    // 1: reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_q", 32'(q), 32'h80);
    chk("rst_addr", 32'(tbl_addr), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_inc", cur_inc, 32'h0);
    chk("rst_busy", 32'(sweep_busy), 32'h0);

    // 2: identity table ramp
    wr(3'd1, 32'h0100_0000);
    wr(3'd0, 32'h01);
    do_sync();
    for (int j = 1; j <= 300; j++) begin
      @(negedge clk);
      chk("ramp_addr", 32'(tbl_addr), 32'((j - 1) & 255));
      if (j >= 3) chk("ramp_q", 32'(q), 32'((j - 3) & 255));
      chk("ramp_wrap", 32'(wrap), 32'(j % 256 == 0));
    end

    // 3: amplitude scaling, inversion, saturation, off state
    tbl_const = 1'b1;
    wr(3'd3, 32'h080);
    wr(3'd0, 32'h03);
    repeat (3) @(negedge clk);
    chk("amp_half_inv", 32'(q), 32'h40);
    wr(3'd0, 32'h01);
    repeat (3) @(negedge clk);
    chk("amp_half", 32'(q), 32'hBF);
    wr(3'd3, 32'h100);
    repeat (3) @(negedge clk);
    chk("amp_unity", 32'(q), 32'hFF);
    wr(3'd3, 32'h1FF);
    repeat (3) @(negedge clk);
    chk("amp_clamp_hi", 32'(q), 32'hFF);
    wr(3'd0, 32'h03);
    repeat (3) @(negedge clk);
    chk("amp_clamp_lo", 32'(q), 32'h00);
    wr(3'd0, 32'h00);
    repeat (3) @(negedge clk);
    chk("off_q", 32'(q), 32'h80);
    wr(3'd3, 32'h100);
    tbl_const = 1'b0;

    // 4: square with and without phase offset, triangle
    wr(3'd1, 32'h0080_0000);
    wr(3'd0, 32'h05);
    do_sync();
    step_to(10);  chk("sq_lo_half", 32'(q), 32'hFF);
    step_to(258); chk("sq_end_half", 32'(q), 32'hFF);
    step_to(259); chk("sq_flip", 32'(q), 32'h00);
    step_to(515); chk("sq_period", 32'(q), 32'hFF);
    wr(3'd2, 32'h8000_0000);
    do_sync();
    step_to(10);  chk("sq_ofs_a", 32'(q), 32'h00);
    step_to(259); chk("sq_ofs_b", 32'(q), 32'hFF);
    wr(3'd2, 32'h0);
    wr(3'd0, 32'h0D);
    do_sync();
    step_to(4);   chk("tri_trough", 32'(q), 32'h00);
    step_to(257); chk("tri_rise", 32'(q), 32'hFE);
    step_to(259); chk("tri_peak", 32'(q), 32'hFF);

    // 5: sweep up, repeat, sweep down
    wr(3'd1, 32'h100);
    wr(3'd4, 32'h100);
    wr(3'd5, 32'h500);
    wr(3'd6, 32'd3);
    wr(3'd0, 32'h11);
    chk("sw_start", cur_inc, 32'h100);
    chk("sw_busy0", 32'(sweep_busy), 32'h1);
    for (int j = 1; j <= 4; j++) begin
      repeat (4) @(negedge clk);
      chk("sw_up_inc", cur_inc, 32'h100 + 32'(j) * 32'h100);
      chk("sw_up_busy", 32'(sweep_busy), 32'(j < 4));
    end
    repeat (4) @(negedge clk);
    chk("sw_done_hold", cur_inc, 32'h500);
    wr(3'd0, 32'h31);
    chk("rp_start", cur_inc, 32'h100);
    for (int j = 1; j <= 4; j++) begin
      repeat (4) @(negedge clk);
      chk("rp_inc", cur_inc, 32'h100 + 32'(j) * 32'h100);
    end
    repeat (4) @(negedge clk);
    chk("rp_reload", cur_inc, 32'h100);
    chk("rp_busy", 32'(sweep_busy), 32'h1);
    repeat (4) @(negedge clk);
    chk("rp_again", cur_inc, 32'h200);
    wr(3'd0, 32'h00);
    chk("rp_idle", 32'(sweep_busy), 32'h0);
    wr(3'd4, 32'hFFFF_FF00);
    wr(3'd1, 32'h500);
    wr(3'd5, 32'h100);
    wr(3'd0, 32'h11);
    chk("dn_start", cur_inc, 32'h500);
    for (int j = 1; j <= 4; j++) begin
      repeat (4) @(negedge clk);
      chk("dn_inc", cur_inc, 32'h500 - 32'(j) * 32'h100);
      chk("dn_busy", 32'(sweep_busy), 32'(j < 4));
    end

    // 6: sync with simultaneous FREQ write mid-sweep, then async reset
    wr(3'd0, 32'h00);
    wr(3'd4, 32'h100);
    wr(3'd5, 32'h500);
    wr(3'd1, 32'h100);
    wr(3'd0, 32'h11);
    @(negedge clk);
    sync = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = 32'h300;
    @(negedge clk);
    sync = 1'b0; cfg_we = 1'b0;
    chk("sy_phase", dut.r_phase, 32'h0);
    chk("sy_inc", cur_inc, 32'h300);
    chk("sy_wrap", 32'(wrap), 32'h0);
    chk("sy_busy", 32'(sweep_busy), 32'h1);
    repeat (3) @(negedge clk);
    chk("sy_q", 32'(q), 32'h00);
    #2 rst = 1'b1;
    #1;
    chk("ar_busy", 32'(sweep_busy), 32'h0);
    chk("ar_inc", cur_inc, 32'h0);
    chk("ar_q", 32'(q), 32'h80);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
